// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: two-stage handshaked modular add/subtract unit.
// A beat is either two packed KW-bit Kyber lanes reduced mod KQ or one
// DW-bit Dilithium word reduced mod DQ. in_mode[0] selects a+b or a-b.
// Stage 1 holds the raw sum or difference. Stage 2 applies one conditional
// correction. Both stages advance together whenever the output slot is free
// or is being drained.
module mod_addsub_pipe #(
  parameter int KW    = 12,
  parameter int DW    = 24,       // packs two Kyber lanes, so DW == 2*KW
  parameter int KQ    = 3329,
  parameter int DQ    = 8380417,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag
);

  // The moduli are widened by one bit so they line up with the carry/borrow
  // bit of the raw results.
  localparam logic [KW:0] KQ_X = KQ[KW:0];
  localparam logic [DW:0] DQ_X = DQ[DW:0];

  // Single correction for one Kyber lane. For sub, the MSB of s is the
  // borrow. For add, the MSB of s is the carry.
  function automatic logic [KW-1:0] fix_lane(input logic [KW:0] s, input logic sub);
    logic [KW:0] t;
    if (sub) begin
      t = s[KW] ? (s + KQ_X) : s;
    end else begin
      t = (s >= KQ_X) ? (s - KQ_X) : s;
    end
    return t[KW-1:0];
  endfunction

  // Single correction for one Dilithium word. It follows the same rule as
  // fix_lane, but at word width.
  function automatic logic [DW-1:0] fix_word(input logic [DW:0] s, input logic sub);
    logic [DW:0] t;
    if (sub) begin
      t = s[DW] ? (s + DQ_X) : s;
    end else begin
      t = (s >= DQ_X) ? (s - DQ_X) : s;
    end
    return t[DW-1:0];
  endfunction

  logic en;

  logic [KW:0] raw_hi;
  logic [KW:0] raw_lo;
  logic [DW:0] raw_w;

  logic             vld_p1;
  logic [1:0]       mode_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [KW:0]      raw_hi_p1;
  logic [KW:0]      raw_lo_p1;
  logic [DW:0]      raw_w_p1;

  logic [DW-1:0]    res_p1;

  logic             vld_p2;
  logic [DW-1:0]    data_p2;
  logic [TAG_W-1:0] tag_p2;

  // The pipeline moves only when the output slot is empty or is being taken.
  // There is no skid buffer, so in_ready follows out_ready combinationally.
  assign en       = ~vld_p2 | out_ready;
  assign in_ready = en;

  // ---- stage 0 -> 1: raw lane/word sums and differences, unreduced ----
  // Compute the lane and word results. Lanes are independent: no carry or
  // borrow crosses the KW boundary.
  always_comb begin
    raw_hi = '0;
    raw_lo = '0;
    raw_w  = '0;
    if (in_mode[0]) begin
      raw_hi = {1'b0, in_a[DW-1:KW]} - {1'b0, in_b[DW-1:KW]};
      raw_lo = {1'b0, in_a[KW-1:0]}  - {1'b0, in_b[KW-1:0]};
      raw_w  = {1'b0, in_a} - {1'b0, in_b};
    end else begin
      raw_hi = {1'b0, in_a[DW-1:KW]} + {1'b0, in_b[DW-1:KW]};
      raw_lo = {1'b0, in_a[KW-1:0]}  + {1'b0, in_b[KW-1:0]};
      raw_w  = {1'b0, in_a} + {1'b0, in_b};
    end
  end

  // Stage-1 valid bit. On every advance it loads in_valid, so bubbles
  // propagate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage-1 payload. It loads only for a real beat, so a bubble leaves the
  // previous contents alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_p1   <= '0;
      tag_p1    <= '0;
      raw_hi_p1 <= '0;
      raw_lo_p1 <= '0;
      raw_w_p1  <= '0;
    end else if (en && in_valid) begin
      mode_p1   <= in_mode;
      tag_p1    <= in_tag;
      raw_hi_p1 <= raw_hi;
      raw_lo_p1 <= raw_lo;
      raw_w_p1  <= raw_w;
    end
  end

  // ---- stage 1 -> 2: one conditional +/-Q correction per lane or word ----
  // Select the corrected result by the mode bit that travelled with the beat.
  always_comb begin
    res_p1 = '0;
    if (mode_p1[1]) begin
      res_p1 = fix_word(raw_w_p1, mode_p1[0]);
    end else begin
      res_p1 = {fix_lane(raw_hi_p1, mode_p1[0]), fix_lane(raw_lo_p1, mode_p1[0])};
    end
  end

  // Output valid bit. It follows the stage-1 valid bit on every advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p2 <= vld_p1;
    end
  end

  // Output payload. It changes only when a real beat moves in, so data and
  // tag stay stable while the output is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p2 <= '0;
      tag_p2  <= '0;
    end else if (en && vld_p1) begin
      data_p2 <= res_p1;
      tag_p2  <= tag_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_tag   = tag_p2;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb_mod_addsub_pipe: directed and streaming checks for mod_addsub_pipe.
// It uses an arithmetic reference model, (a +/- b) mod Q per lane or word,
// together with an expected-beat queue.
module tb_mod_addsub_pipe;
  localparam int KW    = 12;
  localparam int DW    = 24;
  localparam int KQ    = 3329;
  localparam int DQ    = 8380417;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_mode = 2'b00;
  logic [DW-1:0]    in_a = '0;
  logic [DW-1:0]    in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;

  mod_addsub_pipe #(
    .KW(KW), .DW(DW), .KQ(KQ), .DQ(DQ), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  typedef struct {
    logic [DW-1:0]    d;
    logic [TAG_W-1:0] t;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Reference result computed from the arithmetic definition.
  function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    longint x, y, rh, rl, r;
    logic [DW-1:0] res;
    if (m[1]) begin
      x = longint'(a);
      y = longint'(b);
      r = m[0] ? (x - y + DQ) % DQ : (x + y) % DQ;
      res = r[DW-1:0];
    end else begin
      x  = longint'(a[DW-1:KW]);
      y  = longint'(b[DW-1:KW]);
      rh = m[0] ? (x - y + KQ) % KQ : (x + y) % KQ;
      x  = longint'(a[KW-1:0]);
      y  = longint'(b[KW-1:0]);
      rl = m[0] ? (x - y + KQ) % KQ : (x + y) % KQ;
      res = {rh[KW-1:0], rl[KW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] pack(input int hi, input int lo);
    return {hi[KW-1:0], lo[KW-1:0]};
  endfunction

  function automatic logic [DW-1:0] rand_op(input logic [1:0] m);
    int hi, lo;
    if (m[1]) return DW'($urandom_range(DQ - 1, 0));
    hi = int'($urandom_range(KQ - 1, 0));
    lo = int'($urandom_range(KQ - 1, 0));
    return pack(hi, lo);
  endfunction

  // Compare process. It runs on every falling edge and checks the handshake
  // rule, stall stability, and each delivered beat against the model.
  logic             stall_prev = 1'b0;
  logic [DW-1:0]    held_d = '0;
  logic [TAG_W-1:0] held_t = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (stall_prev) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, held_d);
          chk("stall_tag", out_tag, held_t);
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h tag %0d, required no beat",
                     out_data, out_tag);
          end else begin
            e = exp_q.pop_front();
            chk("model_data", out_data, e.d);
            chk("model_tag", out_tag, e.t);
          end
        end
        if (in_valid && in_ready) begin
          e.d = model(in_mode, in_a, in_b);
          e.t = in_tag;
          exp_q.push_back(e);
        end
        stall_prev = out_valid && !out_ready;
        held_d = out_data;
        held_t = out_tag;
      end
    end
  end

  // Send one beat with out_ready high. The task checks that the result
  // appears two cycles after the cycle in which the beat was accepted, and
  // that it equals a hand-computed value.
  task automatic send_one(input string nm, input logic [1:0] m, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [TAG_W-1:0] t,
                          input logic [DW-1:0] req);
    bit acc;
    int k;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_mode = m;
    in_a = a;
    in_b = b;
    in_tag = t;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    chk({nm, "_accept"}, acc, 1);
    k = 1;
    while (!out_valid && k < 12) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, "_latency"}, k, 2);
    chk({nm, "_data"}, out_data, req);
    chk({nm, "_tag"}, out_tag, t);
  endtask

  // Watchdog. Every wait in the bench is bounded, so this only fires if
  // something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]    bm[6];
    logic [DW-1:0] ba[6];
    logic [DW-1:0] bb[6];
    logic [1:0]    seq[4];
    int            n0, idx;
    bit            acc;

    // Reset state. in_ready must be high in reset even with out_ready low.
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed Kyber and Dilithium vectors.
    send_one("ky_add", 2'b00, pack(3000, 100), pack(500, 3328), 8'd17, pack(171, 99));
    send_one("ky_sub", 2'b01, pack(5, 3328), pack(10, 0), 8'd18, pack(3324, 3328));
    send_one("ky_sub_wrap", 2'b01, pack(0, 0), pack(3328, 1), 8'd19, pack(1, 3328));
    send_one("dl_add_wrap", 2'b10, 24'd8380416, 24'd1, 8'd20, 24'd0);
    send_one("dl_add", 2'b10, 24'd4000000, 24'd4000000, 8'd21, 24'd8000000);
    send_one("dl_sub_wrap", 2'b11, 24'd0, 24'd1, 8'd22, 24'd8380416);
    send_one("dl_sub_zero", 2'b11, 24'd5, 24'd5, 8'd23, 24'd0);

    // Backpressure: six beats with tags 1..6 are presented back to back, and
    // out_ready is low in cycles 3-5.
    for (int i = 0; i < 6; i++) begin
      bm[i] = 2'(i);
      ba[i] = rand_op(bm[i]);
      bb[i] = rand_op(bm[i]);
    end
    @(posedge clk);
    #1;
    n0 = n_out;
    idx = 0;
    acc = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (acc) idx++;
      out_ready = !(c >= 3 && c <= 5);
      if (idx < 6) begin
        in_valid = 1'b1;
        in_mode = bm[idx];
        in_a = ba[idx];
        in_b = bb[idx];
        in_tag = 8'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c < 8) chk("bp_in_ready", in_ready, !(c >= 3 && c <= 5));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("bp_delivered", n_out - n0, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Mixed modes: 64 random in-range beats, one per cycle, mode order
    // 00/11/10/01.
    seq[0] = 2'b00;
    seq[1] = 2'b11;
    seq[2] = 2'b10;
    seq[3] = 2'b01;
    n0 = n_out;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_mode = seq[i % 4];
      in_a = rand_op(seq[i % 4]);
      in_b = rand_op(seq[i % 4]);
      in_tag = 8'(i);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mixed_throughput", n_out - n0, 64);

    // Reset mid-stream, with both stages full.
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_mode = 2'b10;
      in_a = 24'(100 + c);
      in_b = 24'd7;
      in_tag = 8'(200 + c);
    end
    chk("pre_rst_out_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_valid", out_valid, 0);
    rst = 1'b1;
    send_one("after_rst", 2'b01, pack(7, 2), pack(3, 9), 8'd99, pack(4, 3322));
    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
